mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one line-wide memory port between an instruction-cache fill port, a
// data-cache fill port and a data-cache write-back (eviction) port. Only one
// memory transaction is ever outstanding. Write-backs always win so that an
// eviction reaches memory before the fill of the same line.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : data-cache fills have fixed priority over instruction fills
//   defined   : contending fills alternate via a 1-bit last-granted pointer,
//               which favours the data cache after reset
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   iReadAddr/Req     : instruction fill request (level), address
//   iReadLine/Valid   : instruction fill data, one-cycle valid pulse
//   dReadAddr/Req     : data fill request (level), address
//   dReadLine/Valid   : data fill data, one-cycle valid pulse
//   dWriteAddr/Line/Req : data write-back request (level), address, data
//   dWriteAck         : one-cycle write-back completion pulse
//   memAddr/WData/WE  : memory command, driven from registers latched at grant
//   memReq            : memory request, held until memAck
//   memRData/memAck   : memory read data, one-cycle completion pulse
//
// Latency with a zero-wait memory: grant cycle, request cycle, response cycle.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ARCH_BITS        = 32,
    parameter int MEMORY_LINE_BITS = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ARCH_BITS-1:0]        iReadAddr,
    input  logic                        iReadReq,
    output logic [MEMORY_LINE_BITS-1:0] iReadLine,
    output logic                        iReadLineValid,
    input  logic [ARCH_BITS-1:0]        dReadAddr,
    input  logic                        dReadReq,
    output logic [MEMORY_LINE_BITS-1:0] dReadLine,
    output logic                        dReadLineValid,
    input  logic [ARCH_BITS-1:0]        dWriteAddr,
    input  logic [MEMORY_LINE_BITS-1:0] dWriteLine,
    input  logic                        dWriteReq,
    output logic                        dWriteAck,
    output logic [ARCH_BITS-1:0]        memAddr,
    output logic [MEMORY_LINE_BITS-1:0] memWData,
    output logic                        memReq,
    output logic                        memWE,
    input  logic [MEMORY_LINE_BITS-1:0] memRData,
    input  logic                        memAck
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester that owns the transaction in flight.
    localparam logic [1:0] ID_DWRITE = 2'd0;
    localparam logic [1:0] ID_DREAD  = 2'd1;
    localparam logic [1:0] ID_IREAD  = 2'd2;

    state_t     state_r;
    state_t     nextState_s;
    logic [1:0] grantId_r;
    logic       grantDRead_s;
    logic       grantIRead_s;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = instruction cache was granted last, so the data cache is favoured.
    logic       lastGrantI_r;

    // Read-grant selection: alternate only when both fills contend.
    always_comb begin
        grantDRead_s = 1'b0;
        grantIRead_s = 1'b0;
        if (dReadReq && iReadReq) begin
            grantDRead_s = lastGrantI_r;
            grantIRead_s = ~lastGrantI_r;
        end else begin
            grantDRead_s = dReadReq;
            grantIRead_s = iReadReq;
        end
    end

    // Last-granted pointer; moves only when a read is actually granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrantI_r <= 1'b1;
        end else if ((state_r == IDLE) && !dWriteReq && (grantDRead_s || grantIRead_s)) begin
            lastGrantI_r <= grantIRead_s;
        end else begin
            lastGrantI_r <= lastGrantI_r;
        end
    end
`else
    // Read-grant selection: data cache has fixed priority.
    always_comb begin
        grantDRead_s = 1'b0;
        grantIRead_s = 1'b0;
        if (dReadReq) begin
            grantDRead_s = 1'b1;
        end else begin
            grantIRead_s = iReadReq;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic; memAck is only meaningful in WRITE and READ.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (dWriteReq) begin
                    nextState_s = WRITE;
                end else if (grantDRead_s || grantIRead_s) begin
                    nextState_s = READ;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WRITE, READ: begin
                if (memAck) begin
                    nextState_s = RESP;
                end else begin
                    nextState_s = state_r;
                end
            end
            RESP:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Registered memory command, grant bookkeeping, fill data and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            memAddr        <= {ARCH_BITS{1'b0}};
            memWData       <= {MEMORY_LINE_BITS{1'b0}};
            memWE          <= 1'b0;
            memReq         <= 1'b0;
            grantId_r      <= ID_DWRITE;
            iReadLine      <= {MEMORY_LINE_BITS{1'b0}};
            dReadLine      <= {MEMORY_LINE_BITS{1'b0}};
            iReadLineValid <= 1'b0;
            dReadLineValid <= 1'b0;
            dWriteAck      <= 1'b0;
        end else begin
            iReadLineValid <= 1'b0;
            dReadLineValid <= 1'b0;
            dWriteAck      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (dWriteReq) begin
                        memAddr   <= dWriteAddr;
                        memWData  <= dWriteLine;
                        memWE     <= 1'b1;
                        memReq    <= 1'b1;
                        grantId_r <= ID_DWRITE;
                    end else if (grantDRead_s) begin
                        memAddr   <= dReadAddr;
                        memWData  <= {MEMORY_LINE_BITS{1'b0}};
                        memWE     <= 1'b0;
                        memReq    <= 1'b1;
                        grantId_r <= ID_DREAD;
                    end else if (grantIRead_s) begin
                        memAddr   <= iReadAddr;
                        memWData  <= {MEMORY_LINE_BITS{1'b0}};
                        memWE     <= 1'b0;
                        memReq    <= 1'b1;
                        grantId_r <= ID_IREAD;
                    end else begin
                        memReq    <= 1'b0;
                    end
                end
                WRITE, READ: begin
                    if (memAck) begin
                        // The pulse set here is visible during RESP.
                        memReq <= 1'b0;
                        case (grantId_r)
                            ID_DWRITE: dWriteAck <= 1'b1;
                            ID_DREAD: begin
                                dReadLine      <= memRData;
                                dReadLineValid <= 1'b1;
                            end
                            ID_IREAD: begin
                                iReadLine      <= memRData;
                                iReadLineValid <= 1'b1;
                            end
                            default: memReq <= 1'b0;
                        endcase
                    end else begin
                        memReq <= 1'b1;
                    end
                end
                RESP:    memReq <= 1'b0;
                default: memReq <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed and randomized scenarios for mem_arbiter. A behavioural memory
// answers memReq after a configurable number of wait cycles and logs every
// completed transaction. For each scenario the expected grant order, fill data,
// response latencies and memory transactions are derived up front from the
// arbitration rules (write first, then the read rule of the selected build).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AB  = 32;
    localparam int LB  = 128;
    localparam int K_W = 0;
    localparam int K_D = 1;
    localparam int K_I = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AB-1:0] iReadAddr, dReadAddr, dWriteAddr, memAddr;
    logic          iReadReq, dReadReq, dWriteReq;
    logic          iReadLineValid, dReadLineValid, dWriteAck;
    logic          memReq, memWE, memAck;
    logic [LB-1:0] iReadLine, dReadLine, dWriteLine, memWData, memRData;

    int total = 0;
    int bad   = 0;
    int waitCycles = 0;
    bit injectAck  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    bit favourI = 1'b0;
`endif

    logic [LB-1:0] memArr [logic [AB-1:0]];
    logic [AB-1:0] logAddr[$];
    logic          logWe[$];
    logic [LB-1:0] logData[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ARCH_BITS(AB), .MEMORY_LINE_BITS(LB)) dut (
        .clk(clk), .rst(rst),
        .iReadAddr(iReadAddr), .iReadReq(iReadReq),
        .iReadLine(iReadLine), .iReadLineValid(iReadLineValid),
        .dReadAddr(dReadAddr), .dReadReq(dReadReq),
        .dReadLine(dReadLine), .dReadLineValid(dReadLineValid),
        .dWriteAddr(dWriteAddr), .dWriteLine(dWriteLine),
        .dWriteReq(dWriteReq), .dWriteAck(dWriteAck),
        .memAddr(memAddr), .memWData(memWData), .memReq(memReq), .memWE(memWE),
        .memRData(memRData), .memAck(memAck)
    );

    // Contents of a never-written memory line.
    function automatic logic [LB-1:0] lineOf(input logic [AB-1:0] a);
        return {a, ~a, a ^ 32'hA5A5_A5A5, 32'h5EED_0000 | a};
    endfunction

    function automatic void noteRead(input int k);
`ifdef ARB_ROUND_ROBIN_EN
        favourI = (k == K_D);
`endif
    endfunction

    // Which read wins when the given fills are pending.
    function automatic int pickRead(input bit dp, input bit ip);
        int k;
`ifdef ARB_ROUND_ROBIN_EN
        if (dp && ip) k = favourI ? K_I : K_D;
        else          k = dp ? K_D : K_I;
`else
        k = dp ? K_D : K_I;
`endif
        noteRead(k);
        return k;
    endfunction

    // Behavioural memory: ack after waitCycles extra cycles of memReq.
    initial begin : responder
        int busy;
        busy = 0;
        memAck = 1'b0;
        memRData = '0;
        forever begin
            @(negedge clk);
            memAck = 1'b0;
            if (injectAck) begin
                injectAck = 1'b0;
                memAck = 1'b1;
                memRData = {4{32'hDEAD_BEEF}};
            end else if (memReq === 1'b1) begin
                if (busy >= waitCycles) begin
                    busy = 0;
                    memAck = 1'b1;
                    logAddr.push_back(memAddr);
                    logWe.push_back(memWE);
                    logData.push_back(memWData);
                    if (memWE) memArr[memAddr] = memWData;
                    else memRData = memArr.exists(memAddr) ? memArr[memAddr] : lineOf(memAddr);
                end else begin
                    busy++;
                end
            end else begin
                busy = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next response pulse; kind=-1 on timeout.
    task automatic waitPulse(input int bound, output int kind, output int lat);
        int np;
        kind = -1;
        lat  = 0;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            np = int'(iReadLineValid) + int'(dReadLineValid) + int'(dWriteAck);
            if (np != 0) begin
                chk("one_pulse", LB'(np), LB'(1));
                kind = dWriteAck ? K_W : (dReadLineValid ? K_D : K_I);
                lat  = n;
                break;
            end
        end
        total++;
        assert (kind >= 0) else begin
            bad++;
            $error("FAIL pulse_timeout observed=none expected=pulse within %0d cycles", bound);
        end
    endtask

    // No pulse and no memory request for n cycles.
    task automatic quiet(input int n, input string tag);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (iReadLineValid !== 1'b0 || dReadLineValid !== 1'b0 ||
                dWriteAck !== 1'b0 || memReq !== 1'b0) ok = 1'b0;
        end
        chk(tag, LB'(ok), LB'(1));
    endtask

    // Each requester holds its request for nX fills, then drops it.
    task automatic runScenario(input int nW, input int nD, input int nI,
                               input logic [AB-1:0] aW, input logic [AB-1:0] aD,
                               input logic [AB-1:0] aI, input logic [LB-1:0] wData);
        int            expKind[$];
        logic [LB-1:0] expLine[$];
        logic [AB-1:0] expAddr[$];
        logic          expWe[$];
        logic [LB-1:0] refMem [logic [AB-1:0]];
        int rW, rD, rI, k, kind, lat, m;
        refMem = memArr;
        rW = nW; rD = nD; rI = nI;
        while (rW + rD + rI > 0) begin
            if (rW > 0) begin
                k = K_W;
                refMem[aW] = wData;
                expAddr.push_back(aW);
                expLine.push_back(wData);
                expWe.push_back(1'b1);
                rW--;
            end else begin
                k = pickRead(rD > 0, rI > 0);
                if (k == K_D) begin
                    expAddr.push_back(aD);
                    expLine.push_back(refMem.exists(aD) ? refMem[aD] : lineOf(aD));
                    rD--;
                end else begin
                    expAddr.push_back(aI);
                    expLine.push_back(refMem.exists(aI) ? refMem[aI] : lineOf(aI));
                    rI--;
                end
                expWe.push_back(1'b0);
            end
            expKind.push_back(k);
        end

        logAddr.delete(); logWe.delete(); logData.delete();
        dWriteAddr = aW; dWriteLine = wData; dReadAddr = aD; iReadAddr = aI;
        dWriteReq = (nW > 0); dReadReq = (nD > 0); iReadReq = (nI > 0);
        rW = nW; rD = nD; rI = nI;
        for (int e = 0; e < expKind.size(); e++) begin
            waitPulse(60, kind, lat);
            if (kind < 0) break;
            chk($sformatf("grant_kind[%0d]", e), LB'(kind), LB'(expKind[e]));
            chk($sformatf("latency[%0d]", e), LB'(lat), LB'(e == 0 ? waitCycles + 2 : waitCycles + 3));
            case (kind)
                K_W: begin
                    rW--;
                    if (rW <= 0) dWriteReq = 1'b0;
                end
                K_D: begin
                    chk($sformatf("dReadLine[%0d]", e), dReadLine, expLine[e]);
                    rD--;
                    if (rD <= 0) dReadReq = 1'b0;
                end
                default: begin
                    chk($sformatf("iReadLine[%0d]", e), iReadLine, expLine[e]);
                    rI--;
                    if (rI <= 0) iReadReq = 1'b0;
                end
            endcase
        end
        dWriteReq = 1'b0; dReadReq = 1'b0; iReadReq = 1'b0;
        quiet(4, "idle_after_scenario");

        chk("mem_log_len", LB'(logAddr.size()), LB'(expAddr.size()));
        m = (logAddr.size() < expAddr.size()) ? logAddr.size() : expAddr.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("memAddr[%0d]", i), LB'(logAddr[i]), LB'(expAddr[i]));
            chk($sformatf("memWE[%0d]", i), LB'(logWe[i]), LB'(expWe[i]));
            if (expWe[i]) chk($sformatf("memWData[%0d]", i), logData[i], expLine[i]);
        end
    endtask

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AB-1:0] a1, a2, a3;
        logic [LB-1:0] expL;
        int kind, lat, nW, nD, nI;

        rst = 1'b1;
        iReadReq = 1'b0; dReadReq = 1'b0; dWriteReq = 1'b0;
        iReadAddr = '0; dReadAddr = '0; dWriteAddr = '0; dWriteLine = '0;
        repeat (3) @(negedge clk);
        chk("rst_memReq", LB'(memReq), LB'(0));
        chk("rst_memWE", LB'(memWE), LB'(0));
        chk("rst_memAddr", LB'(memAddr), LB'(0));
        chk("rst_memWData", memWData, '0);
        chk("rst_iReadLine", iReadLine, '0);
        chk("rst_dReadLine", dReadLine, '0);
        chk("rst_pulses", LB'({iReadLineValid, dReadLineValid, dWriteAck}), LB'(0));
        rst = 1'b0;
        quiet(2, "idle_after_reset");

        // I-cache fill with two memory wait cycles.
        memArr[32'h40] = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        waitCycles = 2;
        runScenario(0, 0, 1, 32'h0, 32'h0, 32'h40, '0);

        // Eviction and fill raised together: write goes first.
        waitCycles = 0;
        runScenario(1, 1, 0, 32'h100, 32'h200, 32'h0, {4{32'hCAFE_F00D}});

        // Write-back then fill of the same line returns the written data.
        waitCycles = 1;
        runScenario(1, 1, 1, 32'h300, 32'h300, 32'h310, {4{32'h1357_9BDF}});

        // Zero-wait latency, memReq the cycle after grant.
        waitCycles = 0;
        iReadAddr = 32'h480;
        iReadReq = 1'b1;
        @(negedge clk);
        chk("lat_memReq", LB'(memReq), LB'(1));
        chk("lat_memWE", LB'(memWE), LB'(0));
        chk("lat_memAddr", LB'(memAddr), LB'(32'h480));
        noteRead(K_I);
        waitPulse(20, kind, lat);
        iReadReq = 1'b0;
        chk("lat_kind", LB'(kind), LB'(K_I));
        chk("lat_cycles", LB'(lat), LB'(1));
        quiet(3, "idle_after_latency");

        // Request dropped right after grant still completes.
        waitCycles = 1;
        expL = memArr.exists(32'h520) ? memArr[32'h520] : lineOf(32'h520);
        dReadAddr = 32'h520;
        dReadReq = 1'b1;
        @(negedge clk);
        dReadReq = 1'b0;
        noteRead(K_D);
        waitPulse(20, kind, lat);
        chk("drop_kind", LB'(kind), LB'(K_D));
        chk("drop_line", dReadLine, expL);
        quiet(3, "idle_after_drop");

        // Stray memAck in IDLE must be ignored.
        injectAck = 1'b1;
        quiet(5, "stray_ack_idle");

        // Reset in the middle of a READ, then a late memAck.
        waitCycles = 5;
        iReadAddr = 32'h640;
        iReadReq = 1'b1;
        @(negedge clk);
        chk("midrd_memReq_up", LB'(memReq), LB'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("midrd_memReq", LB'(memReq), LB'(0));
        chk("midrd_memAddr", LB'(memAddr), LB'(0));
        chk("midrd_iReadLine", iReadLine, '0);
        chk("midrd_dReadLine", dReadLine, '0);
        chk("midrd_pulses", LB'({iReadLineValid, dReadLineValid, dWriteAck}), LB'(0));
        rst = 1'b0;
        iReadReq = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        favourI = 1'b0;
`endif
        injectAck = 1'b1;
        quiet(8, "after_mid_reset");

        // Contention: both fills held for four fills each.
        waitCycles = 0;
        runScenario(0, 4, 4, 32'h0, 32'h700, 32'h780, '0);

        // Randomized mixes.
        for (int it = 0; it < 8; it++) begin
            waitCycles = $urandom_range(0, 3);
            nW = $urandom_range(0, 2);
            nD = $urandom_range(0, 3);
            nI = $urandom_range(0, 3);
            if (nW + nD + nI == 0) nI = 1;
            a1 = AB'($urandom_range(1, 7)) << 4;
            a2 = AB'($urandom_range(1, 7)) << 4;
            a3 = AB'($urandom_range(1, 7)) << 4;
            runScenario(nW, nD, nI, a1, a2, a3, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
